// File: rtl/gpio_apb_regbank.sv
// APB slave register bank for the expander GPIO pins: direction, output data,
// synchronised inputs and per-pin edge interrupts.
module gpio_apb_regbank #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    input  logic [DATA_WIDTH-1:0] gpio_in,
    output logic [DATA_WIDTH-1:0] gpio_out,
    output logic [DATA_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                  state;
    logic                    xfer_write;
    logic [ADDR_WIDTH-1:0]   xfer_addr;
    logic [DATA_WIDTH-1:0]   xfer_data;

    logic [DATA_WIDTH-1:0]   dir_reg;
    logic [DATA_WIDTH-1:0]   out_reg;
    logic [DATA_WIDTH-1:0]   rise_ie;
    logic [DATA_WIDTH-1:0]   fall_ie;
    logic [DATA_WIDTH-1:0]   istat;
    logic [DATA_WIDTH-1:0]   sync_q;
    logic [DATA_WIDTH-1:0]   in_s;
    logic [DATA_WIDTH-1:0]   in_d;

    logic                    commit;
    logic [DATA_WIDTH-1:0]   clr;
    logic [DATA_WIDTH-1:0]   rise;
    logic [DATA_WIDTH-1:0]   fall;
    logic [DATA_WIDTH-1:0]   rd_data;

    assign gpio_out = out_reg;
    assign gpio_oe  = dir_reg;

    // Writes use the address/data latched in WAIT and take effect on the edge leaving DONE.
    assign commit = (state == ST_DONE) && xfer_write;
    assign clr    = (commit && xfer_addr == ADDR_WIDTH'(5)) ? xfer_data : '0;
    assign rise   = in_s & ~in_d & ~dir_reg;
    assign fall   = ~in_s & in_d & ~dir_reg;

    always_comb begin
        rd_data = '0;
        case (paddr)
            ADDR_WIDTH'(0): rd_data = dir_reg;
            ADDR_WIDTH'(1): rd_data = out_reg;
            ADDR_WIDTH'(2): rd_data = in_s;
            ADDR_WIDTH'(3): rd_data = rise_ie;
            ADDR_WIDTH'(4): rd_data = fall_ie;
            ADDR_WIDTH'(5): rd_data = istat;
            default:        rd_data = '0;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state      <= ST_IDLE;
            xfer_write <= 1'b0;
            xfer_addr  <= '0;
            xfer_data  <= '0;
            pready     <= 1'b0;
            prdata     <= '0;
            dir_reg    <= '0;
            out_reg    <= '0;
            rise_ie    <= '0;
            fall_ie    <= '0;
            istat      <= '0;
            irq        <= 1'b0;
            sync_q     <= '0;
            in_s       <= '0;
            in_d       <= '0;
        end else begin
            pready <= 1'b0;
            prdata <= '0;
            case (state)
                ST_IDLE: begin
                    if (psel && !penable) state <= ST_SETUP;
                end
                ST_SETUP: begin
                    if (!psel)        state <= ST_IDLE;
                    else if (penable) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (psel && penable) begin
                        state      <= ST_DONE;
                        pready     <= 1'b1;
                        prdata     <= pwrite ? '0 : rd_data;
                        xfer_write <= pwrite;
                        xfer_addr  <= paddr;
                        xfer_data  <= pwdata;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (commit) begin
                case (xfer_addr)
                    ADDR_WIDTH'(0): dir_reg <= xfer_data;
                    ADDR_WIDTH'(1): out_reg <= xfer_data;
                    ADDR_WIDTH'(3): rise_ie <= xfer_data;
                    ADDR_WIDTH'(4): fall_ie <= xfer_data;
                    ADDR_WIDTH'(6): out_reg <= out_reg | xfer_data;
                    ADDR_WIDTH'(7): out_reg <= out_reg & ~xfer_data;
                    default: ;
                endcase
            end

            // Fresh edges are OR-ed in after the clear, so set wins on a collision.
            istat  <= (istat & ~clr) | (rise & rise_ie) | (fall & fall_ie);
            irq    <= |istat;
            sync_q <= gpio_in;
            in_s   <= sync_q;
            in_d   <= in_s;
        end
    end

endmodule

// File: doc/gpio_apb_regbank.md
# gpio_apb_regbank

APB slave register bank that drives and samples the expander's GPIO pins. Sits directly downstream of the SPI-to-APB bridge: one bit of the bridge's `b_psel` bus selects it. It takes the bridge's APB write/read transfers and returns `prdata`/`pready`. It also owns pin direction, output data, input synchronisation and edge-interrupt capture.

## Interface
- `DATA_WIDTH`, 8: register and GPIO width.
- `ADDR_WIDTH`, 3: APB address width; 8 registers.
- `pclk`  in  1: APB clock, driven from bridge `b_pclk`; all logic on rising edge.
- `preset`  in  1: synchronous, active-high reset.
- `psel`  in  1: slave select; one bit of bridge `b_psel`.
- `penable`  in  1: APB access phase.
- `pwrite`  in  1: 1 = write, 0 = read.
- `paddr`  in  ADDR_WIDTH: register address.
- `pwdata`  in  DATA_WIDTH: write data.
- `prdata`  out  DATA_WIDTH: read data; valid only while `pready`=1, otherwise 0.
- `pready`  out  1: transfer complete, registered, one-cycle pulse.
- `gpio_in`  in  DATA_WIDTH: asynchronous pin inputs.
- `gpio_out`  out  DATA_WIDTH: pin output data (OUT register).
- `gpio_oe`  out  DATA_WIDTH: pin output enable (DIR register); 1 = drive.
- `irq`  out  1: registered OR of ISTAT.

## Operation
- Register map:
  - 0 DIR: R/W.
  - 1 OUT: R/W.
  - 2 IN: RO, synchronised pin value.
  - 3 RISE_IE: R/W.
  - 4 FALL_IE: R/W.
  - 5 ISTAT: read; write-1-to-clear.
  - 6 OUT_SET: WO; OUT |= pwdata; reads 0.
  - 7 OUT_CLR: WO; OUT &= ~pwdata; reads 0.
- Writes to RO register 2 are ignored. No error response; `pready` still pulses.
- Transfer FSM states:
  - IDLE → SETUP on `psel & !penable`.
  - SETUP → WAIT on `psel & penable`; stays in SETUP while `psel & !penable`; → IDLE if `!psel`.
  - WAIT → DONE if `psel & penable` is still high, else → IDLE (abort: no write, no pulse).
  - DONE: `pready`=1 and register commit on this edge; → IDLE unconditionally.
- Address and data are sampled in WAIT, on the cycle before DONE. `pwrite`/`paddr`/`pwdata` must be stable from SETUP through DONE.
- Input path:
  - Two-flop synchroniser `gpio_in` → `in_s`, then one more flop `in_d`.
  - rise = `in_s & ~in_d`; fall = `~in_s & in_d`.
  - Edges count only on bits with DIR=0.
- ISTAT update each cycle: ISTAT = (ISTAT & ~clr) | (rise & RISE_IE) | (fall & FALL_IE).
  - clr = pwdata when a write to address 5 commits, else 0.
  - Set wins over clear on the same bit in the same cycle.
- `irq` = registered |ISTAT.
- Changing DIR does not alter OUT. `gpio_out` always reflects OUT regardless of DIR.

## Timing
- Reset values:
  - All registers 0.
  - Synchroniser flops and `in_d` 0.
  - FSM IDLE.
  - `pready`, `prdata`, `irq`, `gpio_out`, `gpio_oe` all 0.
- `preset` is sampled at `pclk` rising edge. Asserting it mid-transfer forces IDLE and clears all state on that edge. The transfer is lost: no `pready`, no write.
- Transfer latency: SETUP edge, WAIT edge, DONE edge. `pready` is high in the third cycle after `psel` rises (one wait state).
- Write effects (OUT/DIR/IE) are visible on outputs the cycle after DONE.
- Read of IN returns the value two `pclk` edges after the pin changed, not yet through `in_d`.
- Pin edge → ISTAT bit set: 3 edges. ISTAT set → `irq`=1: 1 more edge, so 4 edges total.
- Back-to-back transfers: the bridge may reassert SETUP the cycle after DONE. IDLE absorbs it, and the new SETUP is detected from IDLE on the next edge.
- A W1C on a bit that is being freshly set leaves the bit 1 and `irq` stays 1.

## Test plan
- Reset: assert `preset` 2 cycles → all outputs 0, read of each addr 0–7 returns 0x00.
- R/W: write DIR=0xF0, OUT=0xA5, read both → 0xF0/0xA5, `gpio_oe`=0xF0, `gpio_out`=0xA5; `pready` exactly one cycle, 3 cycles after `psel`.
- Set/clear: OUT=0x0F, write OUT_SET 0x30 → 0x3F; OUT_CLR 0x05 → 0x3A; reads of addr 6/7 → 0x00.
- Interrupt: DIR=0, RISE_IE=0x01, FALL_IE=0x80. Raise `gpio_in[0]` → ISTAT=0x01 after 3 edges, `irq`=1 after 4. Drop `gpio_in[7]` → ISTAT=0x81. W1C 0x01 → 0x80, `irq` stays 1. W1C 0x80 → `irq`=0. Edge on a DIR=1 bit → no set.
- Collision/abort: rising edge on bit 0 lands in the same cycle as a W1C 0x01 commit → ISTAT[0] stays 1. Drop `psel` in WAIT → no `pready`, register unchanged.
- Mid-reset: assert `preset` during WAIT of a write OUT=0xFF → no `pready`, OUT=0x00; next transfer completes normally.
